bcd_ascii_ser: RTL and testbench

BCD_ASCII_SER -- requirements
Module: bcd_ascii_ser

---
 rtl/bcd_ascii_ser_if.sv | 31 +++
 rtl/bcd_ascii_ser.sv | 124 ++++++++++++
 tb/tb_bcd_ascii_ser.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_ascii_ser_if.sv
// Handshake bundle for the BCD-to-ASCII serializer: BCD word in, ASCII characters out.
// Both sides use valid/ready: a beat moves on a clock edge where valid and ready are both 1.
interface bcd_ascii_ser_if;
  logic [39:0] bcd_data_i;
  logic        bcd_data_valid_i;
  logic        bcd_redy_o;
  logic [7:0]  ascii_data_o;
  logic        ascii_valid_o;
  logic        ascii_redy_i;
  logic        busy_o;

  modport slave (
    input  bcd_data_i,
    input  bcd_data_valid_i,
    input  ascii_redy_i,
    output bcd_redy_o,
    output ascii_data_o,
    output ascii_valid_o,
    output busy_o
  );

  modport master (
    output bcd_data_i,
    output bcd_data_valid_i,
    output ascii_redy_i,
    input  bcd_redy_o,
    input  ascii_data_o,
    input  ascii_valid_o,
    input  busy_o
  );
endinterface

// File: rtl/bcd_ascii_ser.sv
// Serializes a 10-digit packed BCD word into ASCII characters, most significant digit first,
// with optional leading-zero suppression and an optional CR/LF terminator.
module bcd_ascii_ser #(
  parameter bit LZ_SUPPRESS = 1'b1,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  bcd_ascii_ser_if.slave     bus,
  output logic [1:0]         state_dbg_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CR   = 2'd2,
    ST_LF   = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [39:0] data_q;
  logic [3:0]  idx_q;
  logic [3:0]  lead_idx;
  logic [3:0]  load_idx;
  logic [3:0]  cur_digit;
  logic        accept;
  logic        xfer;
  logic        bcd_redy;
  logic        asc_valid;
  logic [7:0]  asc_data;
  logic        busy;

  assign accept    = bus.bcd_data_valid_i && bcd_redy;
  assign xfer      = asc_valid && bus.ascii_redy_i;
  assign cur_digit = 4'(data_q >> {idx_q, 2'b00});

  // Highest nonzero digit position wins; an all-zero word leaves 0 so one '0' is sent.
  always_comb begin
    lead_idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (bus.bcd_data_i[i*4 +: 4] != 4'd0) begin
        lead_idx = 4'(i);
      end
    end
  end

  assign load_idx = LZ_SUPPRESS ? lead_idx : 4'd9;

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_SEND;
      ST_SEND: begin
        if (xfer && (idx_q == 4'd0)) begin
          state_d = APPEND_CRLF ? ST_CR : ST_IDLE;
        end
      end
      ST_CR:   if (xfer) state_d = ST_LF;
      ST_LF:   if (xfer) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic; everything is a function of the registered state, so a stall holds it.
  always_comb begin
    bcd_redy  = 1'b0;
    asc_valid = 1'b0;
    asc_data  = 8'h00;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        bcd_redy = 1'b1;
        busy     = 1'b0;
      end
      ST_SEND: begin
        asc_valid = 1'b1;
        asc_data  = (cur_digit <= 4'd9) ? {4'h3, cur_digit} : 8'h3F;
      end
      ST_CR: begin
        asc_valid = 1'b1;
        asc_data  = 8'h0D;
      end
      ST_LF: begin
        asc_valid = 1'b1;
        asc_data  = 8'h0A;
      end
      default: begin
        bcd_redy  = 1'b0;
        asc_valid = 1'b0;
      end
    endcase
  end

  // Captured word and the index of the digit currently presented.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_q <= 40'd0;
      idx_q  <= 4'd0;
    end else if (accept) begin
      data_q <= bus.bcd_data_i;
      idx_q  <= load_idx;
    end else if ((state_q == ST_SEND) && xfer && (idx_q != 4'd0)) begin
      idx_q <= idx_q - 4'd1;
    end
  end

  assign bus.bcd_redy_o    = bcd_redy;
  assign bus.ascii_valid_o = asc_valid;
  assign bus.ascii_data_o  = asc_data;
  assign bus.busy_o        = busy;
  assign state_dbg_o       = state_q;

endmodule

// File: tb/tb_bcd_ascii_ser.sv
// Bench for bcd_ascii_ser: two instances (leading-zero suppression on and off) driven by
// directed and randomized words, checked against a character-queue model of the output text.
module tb_bcd_ascii_ser;

  logic        clk = 1'b0;
  logic        rstn;
  logic [39:0] bcd_data;
  logic [1:0]  bcd_valid;
  logic        ascii_redy;
  logic [1:0]  st0;
  logic [1:0]  st1;

  always #5 clk = ~clk;

  bcd_ascii_ser_if bus0();
  bcd_ascii_ser_if bus1();

  assign bus0.bcd_data_i       = bcd_data;
  assign bus0.bcd_data_valid_i = bcd_valid[0];
  assign bus0.ascii_redy_i     = ascii_redy;
  assign bus1.bcd_data_i       = bcd_data;
  assign bus1.bcd_data_valid_i = bcd_valid[1];
  assign bus1.ascii_redy_i     = ascii_redy;

  bcd_ascii_ser u_dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .bus         (bus0.slave),
    .state_dbg_o (st0)
  );

  bcd_ascii_ser #(.LZ_SUPPRESS(1'b0)) u_dut_nolz (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .bus         (bus1.slave),
    .state_dbg_o (st1)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got0_q[$];
  logic [7:0] got1_q[$];
  bit         tog = 1'b0;
  bit         stall0 = 1'b0;
  bit         stall1 = 1'b0;
  logic [7:0] hold0 = 8'h00;
  logic [7:0] hold1 = 8'h00;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected text: decimal digits from the first significant one down, '?' for non-BCD, then CR LF.
  task automatic build_exp(input logic [39:0] d, input bit lz);
    int top;
    logic [3:0] dig;
    exp_q.delete();
    top = 9;
    if (lz) begin
      top = 0;
      for (int i = 9; i >= 0; i--) begin
        if (d[i*4 +: 4] != 4'd0) begin
          top = i;
          break;
        end
      end
    end
    for (int i = top; i >= 0; i--) begin
      dig = d[i*4 +: 4];
      exp_q.push_back((dig < 4'd10) ? (8'h30 + {4'h0, dig}) : 8'h3F);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  function automatic logic redy_of(input int sel);
    return (sel == 0) ? bus0.bcd_redy_o : bus1.bcd_redy_o;
  endfunction

  function automatic logic valid_of(input int sel);
    return (sel == 0) ? bus0.ascii_valid_o : bus1.ascii_valid_o;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? bus0.busy_o : bus1.busy_o;
  endfunction

  function automatic logic [1:0] state_of(input int sel);
    return (sel == 0) ? st0 : st1;
  endfunction

  // Transfer monitors: a character moves on the posedge after a negedge where valid && ready.
  always @(negedge clk) begin
    if (!rstn) begin
      stall0 = 1'b0;
    end else begin
      if (stall0) begin
        check("stall_valid_held0", bus0.ascii_valid_o, 1'b1);
        check("stall_data_held0", bus0.ascii_data_o, hold0);
      end
      if (bus0.ascii_valid_o && ascii_redy) got0_q.push_back(bus0.ascii_data_o);
      stall0 = bus0.ascii_valid_o && !ascii_redy;
      hold0  = bus0.ascii_data_o;
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      stall1 = 1'b0;
    end else begin
      if (stall1) begin
        check("stall_valid_held1", bus1.ascii_valid_o, 1'b1);
        check("stall_data_held1", bus1.ascii_data_o, hold1);
      end
      if (bus1.ascii_valid_o && ascii_redy) got1_q.push_back(bus1.ascii_data_o);
      stall1 = bus1.ascii_valid_o && !ascii_redy;
      hold1  = bus1.ascii_data_o;
    end
  end

  task automatic drive_ready(input int mode);
    case (mode)
      0:       ascii_redy = 1'b1;
      1:       begin ascii_redy = tog; tog = ~tog; end
      default: ascii_redy = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic compare_got(input int sel);
    logic [7:0] g[$];
    if (sel == 0) g = got0_q;
    else          g = got1_q;
    check("char_count", g.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < g.size()) check($sformatf("char%0d", i), g[i], exp_q[i]);
    end
  endtask

  // Sends one word and follows its stream back to idle. With hold=1 the valid line stays high
  // carrying next_d during the stream; the following call then uses preset=1 for that word.
  task automatic send_word(input int sel, input logic [39:0] d, input int mode,
                           input bit preset, input bit hold, input logic [39:0] next_d);
    int n;
    bit acc_ok;
    bit done;
    build_exp(d, sel == 0);
    if (sel == 0) got0_q.delete();
    else          got1_q.delete();
    if (!preset) begin
      @(posedge clk); #1;
      bcd_data       = d;
      bcd_valid[sel] = 1'b1;
      @(negedge clk);
    end
    acc_ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (redy_of(sel)) begin
        acc_ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept_timeout", acc_ok, 1'b1);
    @(posedge clk); #1;
    if (hold) begin
      bcd_data = next_d;
    end else begin
      bcd_valid[sel] = 1'b0;
      bcd_data       = {8'($urandom), $urandom};
    end
    drive_ready(mode);
    n    = 0;
    done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (redy_of(sel)) begin
        done = 1'b1;
        break;
      end
      if (n == 0) check("first_char_latency", valid_of(sel), 1'b1);
      check("busy_in_stream", busy_of(sel), 1'b1);
      n++;
      @(posedge clk); #1;
      drive_ready(mode);
    end
    check("stream_end_timeout", done, 1'b1);
    if (mode == 0) check("cycles_for_word", n, exp_q.size());
    check("idle_busy_low", busy_of(sel), 1'b0);
    check("idle_state", state_of(sel), 2'd0);
    compare_got(sel);
  endtask

  function automatic logic [39:0] random_word();
    logic [39:0] w;
    int lz;
    w  = 40'd0;
    lz = $urandom_range(0, 10);
    for (int i = 0; i < 10; i++) begin
      if (i < 10 - lz) begin
        w[i*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                  : 4'($urandom_range(0, 9));
      end
    end
    return w;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn       = 1'b0;
    bcd_data   = 40'd0;
    bcd_valid  = 2'b00;
    ascii_redy = 1'b0;
    #1;
    check("rst_valid0", bus0.ascii_valid_o, 1'b0);
    check("rst_data0", bus0.ascii_data_o, 8'h00);
    check("rst_busy0", bus0.busy_o, 1'b0);
    check("rst_state0", st0, 2'd0);
    check("rst_valid1", bus1.ascii_valid_o, 1'b0);
    check("rst_busy1", bus1.busy_o, 1'b0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("redy_after_reset0", bus0.bcd_redy_o, 1'b1);
    check("redy_after_reset1", bus1.bcd_redy_o, 1'b1);

    // Directed words
    send_word(0, 40'h0000000000, 0, 1'b0, 1'b0, 40'd0);
    send_word(0, 40'h4294967295, 0, 1'b0, 1'b0, 40'd0);
    send_word(0, 40'h0000012345, 1, 1'b0, 1'b0, 40'd0);
    send_word(0, 40'h00000000A7, 0, 1'b0, 1'b0, 40'd0);
    send_word(1, 40'h00000000A7, 0, 1'b0, 1'b0, 40'd0);
    send_word(1, 40'h0000000000, 1, 1'b0, 1'b0, 40'd0);

    // Valid held high with a new word during a stream
    send_word(0, 40'h0000009999, 0, 1'b0, 1'b1, 40'h0000000555);
    send_word(0, 40'h0000000555, 0, 1'b1, 1'b0, 40'd0);

    // Reset in the middle of a stream
    @(posedge clk); #1;
    bcd_data     = 40'h9876543210;
    bcd_valid[0] = 1'b1;
    ascii_redy   = 1'b1;
    got0_q.delete();
    @(negedge clk);
    check("mid_reset_accept_redy", bus0.bcd_redy_o, 1'b1);
    @(posedge clk); #1;
    bcd_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_char", bus0.ascii_data_o, 8'h36);
    rstn = 1'b0;
    #1;
    check("async_reset_valid", bus0.ascii_valid_o, 1'b0);
    check("async_reset_data", bus0.ascii_data_o, 8'h00);
    check("async_reset_busy", bus0.busy_o, 1'b0);
    check("async_reset_state", st0, 2'd0);
    exp_q.delete();
    exp_q.push_back(8'h39);
    exp_q.push_back(8'h38);
    exp_q.push_back(8'h37);
    compare_got(0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    got0_q.delete();
    repeat (4) @(negedge clk);
    check("no_chars_after_reset", got0_q.size(), 0);
    check("redy_after_mid_reset", bus0.bcd_redy_o, 1'b1);
    send_word(0, 40'h0000000042, 0, 1'b0, 1'b0, 40'd0);

    // Randomized words, instances and downstream ready patterns
    for (int t = 0; t < 24; t++) begin
      send_word($urandom_range(0, 1), random_word(), $urandom_range(0, 2), 1'b0, 1'b0, 40'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
